// File: rtl/store_align_pkg.sv
// Shared definitions for the store alignment path: width codes (common with
// the load reduce path), FSM state encoding and the byte-mask lookup.
package store_align_pkg;

   localparam logic [1:0] WIDTH_WORD = 2'b00;
   localparam logic [1:0] WIDTH_RSVD = 2'b01;
   localparam logic [1:0] WIDTH_HALF = 2'b10;
   localparam logic [1:0] WIDTH_BYTE = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BEAT1 = 2'd1,
      ST_BEAT2 = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Reserved code yields an empty mask; callers flag it separately.
   function automatic logic [3:0] width_mask(input logic [1:0] width);
      logic [3:0] mask;
      case (width)
         WIDTH_WORD: mask = 4'b1111;
         WIDTH_HALF: mask = 4'b0011;
         WIDTH_BYTE: mask = 4'b0001;
         default:    mask = 4'b0000;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/store_align_if.sv
// Request and data-memory write-port bundle for store_align.
interface store_align_if;
   logic        ReqValid;
   logic        ReqReady;
   logic [31:0] ReqAddr;
   logic [31:0] ReqData;
   logic [2:0]  WidthSrc;
   logic        MemValid;
   logic        MemReady;
   logic [31:0] MemAddr;
   logic [3:0]  MemByteEn;
   logic [31:0] MemWData;
   logic        StoreDone;
   logic        StoreErr;

   modport slave (
      input  ReqValid, ReqAddr, ReqData, WidthSrc, MemReady,
      output ReqReady, MemValid, MemAddr, MemByteEn, MemWData, StoreDone, StoreErr
   );

   modport master (
      output ReqValid, ReqAddr, ReqData, WidthSrc, MemReady,
      input  ReqReady, MemValid, MemAddr, MemByteEn, MemWData, StoreDone, StoreErr
   );
endinterface

// File: rtl/store_lane_shift.sv
// Combinational lane placement: spreads a right-justified store across an
// 8-byte window starting at the word containing the address.
module store_lane_shift
   import store_align_pkg::*;
(
   input  logic [1:0]  off,
   input  logic [1:0]  width,
   input  logic [31:0] data,
   output logic [7:0]  mask8,
   output logic [63:0] data64,
   output logic        needs_beat2,
   output logic        width_err
);

   assign mask8       = {4'b0000, width_mask(width)} << off;
   assign data64      = {32'd0, data} << {off, 3'b000};
   assign needs_beat2 = |mask8[7:4];
   assign width_err   = (width == WIDTH_RSVD);

endmodule

// File: rtl/store_align.sv
// Store request to data-memory write converter; word-crossing stores are
// issued as two back-to-back beats or rejected, depending on SPLIT_MISALIGNED.
module store_align
   import store_align_pkg::*;
#(
   parameter bit SPLIT_MISALIGNED = 1'b1
)(
   input  logic         clk,
   input  logic         reset,
   store_align_if.slave bus
);

   logic [7:0]  mask8;
   logic [63:0] data64;
   logic        needs_beat2;
   logic        width_err;

   store_lane_shift u_lane_shift (
      .off         (bus.ReqAddr[1:0]),
      .width       (bus.WidthSrc[1:0]),
      .data        (bus.ReqData),
      .mask8       (mask8),
      .data64      (data64),
      .needs_beat2 (needs_beat2),
      .width_err   (width_err)
   );

   logic unused_width_hi;
   assign unused_width_hi = bus.WidthSrc[2];

   state_t      state_reg, state_next;
   logic        mem_valid_reg, mem_valid_next;
   logic [31:0] mem_addr_reg, mem_addr_next;
   logic [3:0]  mem_be_reg, mem_be_next;
   logic [31:0] mem_wdata_reg, mem_wdata_next;
   logic [3:0]  hi_be_reg, hi_be_next;
   logic [31:0] hi_data_reg, hi_data_next;
   logic        done_reg, done_next;
   logic        err_reg, err_next;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= ST_IDLE;
         mem_valid_reg <= 1'b0;
         mem_addr_reg  <= 32'd0;
         mem_be_reg    <= 4'd0;
         mem_wdata_reg <= 32'd0;
         hi_be_reg     <= 4'd0;
         hi_data_reg   <= 32'd0;
         done_reg      <= 1'b0;
         err_reg       <= 1'b0;
      end else begin
         state_reg     <= state_next;
         mem_valid_reg <= mem_valid_next;
         mem_addr_reg  <= mem_addr_next;
         mem_be_reg    <= mem_be_next;
         mem_wdata_reg <= mem_wdata_next;
         hi_be_reg     <= hi_be_next;
         hi_data_reg   <= hi_data_next;
         done_reg      <= done_next;
         err_reg       <= err_next;
      end
   end

   // Beat 1 goes straight to the output registers at acceptance; the upper
   // half of the window is parked so beat 2 can follow on the next handshake.
   always_comb begin
      state_next     = state_reg;
      mem_valid_next = mem_valid_reg;
      mem_addr_next  = mem_addr_reg;
      mem_be_next    = mem_be_reg;
      mem_wdata_next = mem_wdata_reg;
      hi_be_next     = hi_be_reg;
      hi_data_next   = hi_data_reg;
      done_next      = 1'b0;
      err_next       = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (bus.ReqValid) begin
               if (width_err || (needs_beat2 && !SPLIT_MISALIGNED)) begin
                  state_next = ST_DONE;
                  done_next  = 1'b1;
                  err_next   = 1'b1;
               end else begin
                  state_next     = ST_BEAT1;
                  mem_valid_next = 1'b1;
                  mem_addr_next  = {bus.ReqAddr[31:2], 2'b00};
                  mem_be_next    = mask8[3:0];
                  mem_wdata_next = data64[31:0];
                  hi_be_next     = mask8[7:4];
                  hi_data_next   = data64[63:32];
               end
            end
         end
         ST_BEAT1: begin
            if (bus.MemReady) begin
               if (hi_be_reg != 4'd0) begin
                  state_next     = ST_BEAT2;
                  mem_addr_next  = mem_addr_reg + 32'd4;
                  mem_be_next    = hi_be_reg;
                  mem_wdata_next = hi_data_reg;
               end else begin
                  state_next     = ST_DONE;
                  mem_valid_next = 1'b0;
                  done_next      = 1'b1;
               end
            end
         end
         ST_BEAT2: begin
            if (bus.MemReady) begin
               state_next     = ST_DONE;
               mem_valid_next = 1'b0;
               done_next      = 1'b1;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign bus.ReqReady  = (state_reg == ST_IDLE);
   assign bus.MemValid  = mem_valid_reg;
   assign bus.MemAddr   = mem_addr_reg;
   assign bus.MemByteEn = mem_be_reg;
   assign bus.MemWData  = mem_wdata_reg;
   assign bus.StoreDone = done_reg;
   assign bus.StoreErr  = err_reg;

endmodule

// File: tb/tb_store_align.sv
// Directed table-driven bench for store_align plus hand sequences for
// reject-on-misalign and reset in the middle of a split store.
module tb_store_align;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   store_align_if bus ();
   store_align_if nbus ();

   store_align #(.SPLIT_MISALIGNED(1'b1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   store_align #(.SPLIT_MISALIGNED(1'b0)) dut_nosplit (
      .clk   (clk),
      .reset (reset),
      .bus   (nbus)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [2:0]  width;
      int          stall;
      int          beats;
      logic        err;
      logic [31:0] a1;
      logic [3:0]  e1;
      logic [31:0] d1;
      logic [31:0] a2;
      logic [3:0]  e2;
      logic [31:0] d2;
   } vec_t;

   int total = 0;
   int bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic chk_beat(input string tag, input vec_t v, input int b);
      chk({tag, " valid"}, 32'(bus.MemValid), 32'd1);
      chk({tag, " addr"},  bus.MemAddr,        (b == 0) ? v.a1 : v.a2);
      chk({tag, " be"},    32'(bus.MemByteEn), 32'((b == 0) ? v.e1 : v.e2));
      chk({tag, " wdata"}, bus.MemWData,       (b == 0) ? v.d1 : v.d2);
   endtask

   // Inputs are driven and outputs sampled on the falling edge.
   task automatic run_vec(input int idx, input vec_t v);
      int bad0;
      bad0 = bad;
      bus.ReqValid = 1'b1;
      bus.ReqAddr  = v.addr;
      bus.ReqData  = v.data;
      bus.WidthSrc = v.width;
      bus.MemReady = 1'b0;
      chk("req_ready idle", 32'(bus.ReqReady), 32'd1);
      @(negedge clk);
      bus.ReqValid = 1'b0;
      bus.ReqAddr  = ~v.addr;
      bus.ReqData  = ~v.data;
      bus.WidthSrc = 3'b001;
      for (int b = 0; b < v.beats; b++) begin
         for (int s = 0; s < v.stall; s++) begin
            bus.MemReady = 1'b0;
            chk_beat("beat stalled", v, b);
            @(negedge clk);
         end
         bus.MemReady = 1'b1;
         chk_beat("beat", v, b);
         @(negedge clk);
      end
      bus.MemReady = 1'b0;
      chk("done pulse",      32'(bus.StoreDone), 32'd1);
      chk("err pulse",       32'(bus.StoreErr),  32'(v.err));
      chk("valid in done",   32'(bus.MemValid),  32'd0);
      chk("req_ready done",  32'(bus.ReqReady),  32'd0);
      @(negedge clk);
      chk("done cleared",    32'(bus.StoreDone), 32'd0);
      chk("req_ready after", 32'(bus.ReqReady),  32'd1);
      $display("txn %0d addr=%h width=%0d beats=%0d err=%0d %s",
               idx, v.addr, v.width, v.beats, v.err, (bad == bad0) ? "ok" : "bad");
   endtask

   vec_t vecs [8];

   initial begin
      vecs[0] = '{32'h00000100, 32'hDEADBEEF, 3'b000, 0, 1, 1'b0,
                  32'h00000100, 4'b1111, 32'hDEADBEEF, 32'h0, 4'h0, 32'h0};
      vecs[1] = '{32'h00000103, 32'h123456AB, 3'b011, 0, 1, 1'b0,
                  32'h00000100, 4'b1000, 32'hAB000000, 32'h0, 4'h0, 32'h0};
      vecs[2] = '{32'h00000103, 32'h0000CAFE, 3'b010, 0, 2, 1'b0,
                  32'h00000100, 4'b1000, 32'hFE000000, 32'h00000104, 4'b0001, 32'h000000CA};
      vecs[3] = '{32'h00000102, 32'h11223344, 3'b000, 3, 2, 1'b0,
                  32'h00000100, 4'b1100, 32'h33440000, 32'h00000104, 4'b0011, 32'h00001122};
      vecs[4] = '{32'hFFFFFFFE, 32'hA1B2C3D4, 3'b000, 1, 2, 1'b0,
                  32'hFFFFFFFC, 4'b1100, 32'hC3D40000, 32'h00000000, 4'b0011, 32'h0000A1B2};
      vecs[5] = '{32'h00000200, 32'h55555555, 3'b001, 0, 0, 1'b1,
                  32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
      vecs[6] = '{32'h00000102, 32'hFFFF5678, 3'b110, 0, 1, 1'b0,
                  32'h00000100, 4'b1100, 32'h56780000, 32'h0, 4'h0, 32'h0};
      vecs[7] = '{32'h00000001, 32'h000000EE, 3'b111, 2, 1, 1'b0,
                  32'h00000000, 4'b0010, 32'h0000EE00, 32'h0, 4'h0, 32'h0};

      bus.ReqValid = 1'b0;  bus.ReqAddr = 32'd0;  bus.ReqData = 32'd0;
      bus.WidthSrc = 3'd0;  bus.MemReady = 1'b0;
      nbus.ReqValid = 1'b0; nbus.ReqAddr = 32'd0; nbus.ReqData = 32'd0;
      nbus.WidthSrc = 3'd0; nbus.MemReady = 1'b1;
      reset = 1'b1;
      repeat (3) @(negedge clk);

      chk("rst valid", 32'(bus.MemValid),  32'd0);
      chk("rst addr",  bus.MemAddr,        32'd0);
      chk("rst be",    32'(bus.MemByteEn), 32'd0);
      chk("rst wdata", bus.MemWData,       32'd0);
      chk("rst done",  32'(bus.StoreDone), 32'd0);
      chk("rst err",   32'(bus.StoreErr),  32'd0);
      chk("rst ready", 32'(bus.ReqReady),  32'd1);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         run_vec(i, vecs[i]);
      end

      // Word-crossing store rejected when splitting is disabled.
      nbus.ReqValid = 1'b1;
      nbus.ReqAddr  = 32'hFFFFFFFE;
      nbus.ReqData  = 32'hA1B2C3D4;
      nbus.WidthSrc = 3'b000;
      @(negedge clk);
      nbus.ReqValid = 1'b0;
      chk("nosplit valid", 32'(nbus.MemValid),  32'd0);
      chk("nosplit done",  32'(nbus.StoreDone), 32'd1);
      chk("nosplit err",   32'(nbus.StoreErr),  32'd1);
      @(negedge clk);
      chk("nosplit valid after", 32'(nbus.MemValid),  32'd0);
      chk("nosplit ready after", 32'(nbus.ReqReady),  32'd1);
      $display("txn nosplit addr=fffffffe %s", "checked");

      // Aligned store still writes with splitting disabled.
      nbus.ReqValid = 1'b1;
      nbus.ReqAddr  = 32'h00000040;
      nbus.ReqData  = 32'h0BADF00D;
      @(negedge clk);
      nbus.ReqValid = 1'b0;
      chk("nosplit aligned valid", 32'(nbus.MemValid),  32'd1);
      chk("nosplit aligned be",    32'(nbus.MemByteEn), 32'hF);
      chk("nosplit aligned data",  nbus.MemWData,       32'h0BADF00D);
      @(negedge clk);
      chk("nosplit aligned done",  32'(nbus.StoreDone), 32'd1);
      chk("nosplit aligned err",   32'(nbus.StoreErr),  32'd0);
      @(negedge clk);
      $display("txn nosplit addr=00000040 %s", "checked");

      // Reset while beat 2 is stalled abandons the request.
      bus.ReqValid = 1'b1;
      bus.ReqAddr  = 32'h00000103;
      bus.ReqData  = 32'h0000CAFE;
      bus.WidthSrc = 3'b010;
      bus.MemReady = 1'b0;
      @(negedge clk);
      bus.ReqValid = 1'b0;
      bus.MemReady = 1'b1;
      @(negedge clk);
      bus.MemReady = 1'b0;
      chk("midrst beat2 valid", 32'(bus.MemValid), 32'd1);
      chk("midrst beat2 addr",  bus.MemAddr,       32'h00000104);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst valid", 32'(bus.MemValid),  32'd0);
      chk("midrst ready", 32'(bus.ReqReady),  32'd1);
      chk("midrst done",  32'(bus.StoreDone), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("midrst done later",  32'(bus.StoreDone), 32'd0);
      chk("midrst valid later", 32'(bus.MemValid),  32'd0);
      $display("txn reset-mid-beat2 %s", "checked");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
